// File: rtl/game_pkg.sv
// Shared game-wide constants, FSM state encoding and small helpers for the
// Chicken Cha-Cha-Cha controller and datapath blocks.
package game_pkg;

  localparam int N_CARDS  = 16;
  localparam int CARD_W   = 4;
  localparam int PLAYER_W = 2;
  localparam int TILE_W   = 5;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_FLIP,
    CHECK,
    CHECK_WAIT,
    MOVE,
    WIN_WAIT,
    REVEAL,
    NEXT,
    GAMEOVER
  } turn_state_t;

  // A player index above the last seat (N lowered mid-game) also wraps to 0.
  function automatic logic [PLAYER_W-1:0] next_player(input logic [PLAYER_W-1:0] cur,
                                                      input logic [PLAYER_W-1:0] last);
    return (cur >= last) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Signal bundle between the turn controller and its surroundings
// (button/card-select front end on the input side, data_path on both sides).
interface turn_controller_if;
  import game_pkg::*;

  logic                start;
  logic                flip_req;
  logic [CARD_W-1:0]   flip_card;
  logic [PLAYER_W-1:0] N;
  logic                go;
  logic                W;

  logic                A;
  logic                B;
  logic                statecombo_next_turn;
  logic [CARD_W-1:0]   position_data;
  logic [PLAYER_W-1:0] player;
  logic [N_CARDS-1:0]  face_up;
  logic                game_over;
  logic [PLAYER_W-1:0] winner;

  modport master (
    output start, flip_req, flip_card, N, go, W,
    input  A, B, statecombo_next_turn, position_data, player, face_up, game_over, winner
  );

  modport slave (
    input  start, flip_req, flip_card, N, go, W,
    output A, B, statecombo_next_turn, position_data, player, face_up, game_over, winner
  );

endinterface

// File: rtl/turn_controller_reveal_timer.sv
// Loadable down-counter that times how long a mismatched card stays on display.
// done is high during the last counted cycle so the caller leaves on time.
module reveal_timer #(
  parameter int unsigned CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(CYCLES);
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/turn_controller.sv
// Turn sequencer: accepts card flips, strobes the datapath compare/move checks,
// holds mismatches on display and rotates the turn among players 0..N.
module turn_controller
  import game_pkg::*;
#(
  parameter int unsigned REVEAL_CYCLES = 50_000_000
) (
  input logic              clk,
  input logic              rst,
  turn_controller_if.slave bus
);

  turn_state_t         state, state_n;
  logic                cmp_strobe, cmp_strobe_n;
  logic                move_strobe, move_strobe_n;
  logic                turn_strobe, turn_strobe_n;
  logic [CARD_W-1:0]   pos, pos_n;
  logic [PLAYER_W-1:0] player, player_n;
  logic [N_CARDS-1:0]  face, face_n;
  logic                over;
  logic [PLAYER_W-1:0] winner, winner_n;
  logic                timer_load;
  logic                timer_done;

  reveal_timer #(.CYCLES(REVEAL_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (state == REVEAL),
    .done (timer_done)
  );

  // Strobes are computed on the transition into their state so that the
  // registered copies line up exactly with CHECK, MOVE and NEXT.
  always_comb begin
    state_n       = state;
    cmp_strobe_n  = 1'b0;
    move_strobe_n = 1'b0;
    turn_strobe_n = 1'b0;
    pos_n         = pos;
    player_n      = player;
    face_n        = face;
    winner_n      = winner;
    timer_load    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n  = WAIT_FLIP;
          player_n = '0;
          face_n   = '0;
        end
      end
      WAIT_FLIP: begin
        if (bus.flip_req && !face[bus.flip_card]) begin
          pos_n                 = bus.flip_card;
          face_n[bus.flip_card] = 1'b1;
          cmp_strobe_n          = 1'b1;
          state_n               = CHECK;
        end
      end
      CHECK: state_n = CHECK_WAIT;
      CHECK_WAIT: begin
        if (bus.go) begin
          move_strobe_n = 1'b1;
          state_n       = MOVE;
        end else begin
          timer_load = 1'b1;
          state_n    = REVEAL;
        end
      end
      MOVE: state_n = WIN_WAIT;
      WIN_WAIT: begin
        if (bus.W) begin
          winner_n = player;
          state_n  = GAMEOVER;
        end else begin
          state_n = WAIT_FLIP;
        end
      end
      REVEAL: begin
        if (timer_done) begin
          turn_strobe_n = 1'b1;
          state_n       = NEXT;
        end
      end
      NEXT: begin
        face_n   = '0;
        player_n = next_player(player, bus.N);
        state_n  = WAIT_FLIP;
      end
      GAMEOVER: begin
        if (bus.start) begin
          player_n = '0;
          face_n   = '0;
          winner_n = '0;
          state_n  = WAIT_FLIP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cmp_strobe  <= 1'b0;
      move_strobe <= 1'b0;
      turn_strobe <= 1'b0;
      pos         <= '0;
      player      <= '0;
      face        <= '0;
      over        <= 1'b0;
      winner      <= '0;
    end else begin
      state       <= state_n;
      cmp_strobe  <= cmp_strobe_n;
      move_strobe <= move_strobe_n;
      turn_strobe <= turn_strobe_n;
      pos         <= pos_n;
      player      <= player_n;
      face        <= face_n;
      over        <= (state_n == GAMEOVER);
      winner      <= winner_n;
    end
  end

  assign bus.A                    = cmp_strobe;
  assign bus.B                    = move_strobe;
  assign bus.statecombo_next_turn = turn_strobe;
  assign bus.position_data        = pos;
  assign bus.player               = player;
  assign bus.face_up              = face;
  assign bus.game_over            = over;
  assign bus.winner               = winner;

endmodule

// File: tb/tb_turn_controller.sv
// Randomised scoreboard bench for turn_controller: a turn-level game model
// queues expected strobe events, an independent monitor checks what appears.
module tb_turn_controller;
  import game_pkg::*;

  localparam int R = 4;

  typedef enum int {EV_A, EV_B, EV_NT, EV_WIN, EV_RESTART, EV_BAD} ev_t;
  typedef struct {
    ev_t         kind;
    int          cyc;
    logic [3:0]  pos;
    logic [1:0]  player;
    logic [15:0] face;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  logic [15:0] m_face   = '0;
  logic [1:0]  m_player = '0;
  logic [3:0]  m_pos    = '0;
  logic        m_over   = 1'b0;
  logic        m_idle   = 1'b1;

  turn_controller_if bus();

  turn_controller #(.REVEAL_CYCLES(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every strobe or game_over edge must match the oldest expectation.
  logic over_prev = 1'b0;
  always @(negedge clk) begin
    ev_t  k;
    exp_t e;
    bit   fire;
    int   nstrobe;
    fire    = 1'b1;
    k       = EV_BAD;
    nstrobe = int'(bus.A) + int'(bus.B) + int'(bus.statecombo_next_turn);
    if (nstrobe > 1)                     k = EV_BAD;
    else if (bus.A)                      k = EV_A;
    else if (bus.B)                      k = EV_B;
    else if (bus.statecombo_next_turn)   k = EV_NT;
    else if (bus.game_over && !over_prev) k = EV_WIN;
    else if (!bus.game_over && over_prev) k = EV_RESTART;
    else                                 fire = 1'b0;
    over_prev = bus.game_over;
    if (rst && fire) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected event: got kind %0d, expected none (cycle %0d)", k, cyc);
      end else begin
        e = q.pop_front();
        check("event kind", k, e.kind);
        check("event cycle", cyc, e.cyc);
        check("position_data", bus.position_data, e.pos);
        check("player", bus.player, e.player);
        check("face_up", bus.face_up, e.face);
        if (e.kind == EV_WIN) check("winner", bus.winner, e.player);
      end
    end
  end

  task automatic do_reset();
    bus.flip_req = 1'b0;
    bus.start    = 1'b0;
    rst          = 1'b0;
    q.delete();
    step();
    rst = 1'b1;
    check("reset A", bus.A, 0);
    check("reset B", bus.B, 0);
    check("reset next_turn", bus.statecombo_next_turn, 0);
    check("reset position_data", bus.position_data, 0);
    check("reset player", bus.player, 0);
    check("reset face_up", bus.face_up, 0);
    check("reset game_over", bus.game_over, 0);
    check("reset winner", bus.winner, 0);
    m_face   = '0;
    m_player = '0;
    m_pos    = '0;
    m_over   = 1'b0;
    m_idle   = 1'b1;
  endtask

  task automatic do_start();
    step();
    bus.start = 1'b1;
    if (m_over) q.push_back('{EV_RESTART, cyc + 1, m_pos, 2'd0, 16'd0});
    m_over   = 1'b0;
    m_idle   = 1'b0;
    m_player = '0;
    m_face   = '0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_ignored(input logic [3:0] card);
    step();
    bus.flip_req  = 1'b1;
    bus.flip_card = card;
    step();
    bus.flip_req = 1'b0;
  endtask

  // One accepted flip with the datapath answering go_v / w_v; while busy,
  // junk flips and starts are thrown in and must have no effect.
  task automatic do_flip(input logic [3:0] card, input logic go_v, input logic w_v, input bit abort);
    int c;
    int fin;
    step();
    c             = cyc;
    bus.flip_req  = 1'b1;
    bus.flip_card = card;
    bus.go        = ~go_v;
    bus.W         = ~w_v;
    m_face[card]  = 1'b1;
    m_pos         = card;
    q.push_back('{EV_A, c + 1, card, m_player, m_face});
    if (go_v) begin
      q.push_back('{EV_B, c + 3, card, m_player, m_face});
      if (w_v) begin
        q.push_back('{EV_WIN, c + 5, card, m_player, m_face});
        m_over = 1'b1;
      end
      fin = c + 5;
    end else begin
      q.push_back('{EV_NT, c + 3 + R, card, m_player, m_face});
      m_face   = '0;
      m_player = (m_player >= bus.N) ? 2'd0 : m_player + 2'd1;
      fin      = c + 4 + R;
    end
    while (cyc < fin) begin
      step();
      if (abort && !go_v && cyc == c + 4) begin
        do_reset();
        return;
      end
      bus.flip_req  = (cyc < fin) && ($urandom_range(3) == 0);
      bus.flip_card = 4'($urandom_range(15));
      bus.start     = (cyc < fin) && ($urandom_range(5) == 0);
      bus.go        = (cyc == c + 2) ? go_v : ~go_v;
      bus.W         = (cyc == c + 4) ? w_v : ~w_v;
    end
    bus.flip_req = 1'b0;
    bus.start    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    bus.start     = 1'b0;
    bus.flip_req  = 1'b0;
    bus.flip_card = '0;
    bus.N         = 2'd2;
    bus.go        = 1'b0;
    bus.W         = 1'b0;
    step();
    do_reset();
    do_start();
    check("start player", bus.player, 0);
    check("start face_up", bus.face_up, 0);
    check("start strobes", {bus.A, bus.B, bus.statecombo_next_turn}, 0);

    do_flip(4'd5, 1'b1, 1'b0, 1'b0);
    check("face_up after match", bus.face_up, 16'h0020);
    do_ignored(4'd5);
    do_flip(4'd3, 1'b0, 1'b0, 1'b0);
    check("player after mismatch", bus.player, 1);
    do_flip(4'd7, 1'b0, 1'b0, 1'b0);
    do_flip(4'd9, 1'b0, 1'b0, 1'b0);
    check("player wrap at N", bus.player, 0);
    do_flip(4'd1, 1'b0, 1'b0, 1'b0);
    do_flip(4'd2, 1'b1, 1'b1, 1'b0);
    check("game_over", bus.game_over, 1);
    check("winner", bus.winner, 1);
    do_ignored(4'd4);
    do_start();
    check("restart game_over", bus.game_over, 0);
    do_flip(4'd6, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      if (m_over || m_idle) begin
        if (m_over && $urandom_range(1) == 0) do_ignored(4'($urandom_range(15)));
        do_start();
      end
      if ($urandom_range(4) == 0) bus.N = 2'($urandom_range(3));
      if (m_face == 16'hFFFF) begin
        do_ignored(4'($urandom_range(15)));
        do_reset();
        continue;
      end
      if (m_face != 16'h0 && $urandom_range(2) == 0) begin
        k = $urandom_range(15);
        while (!m_face[k]) k = (k + 1) % 16;
        do_ignored(4'(k));
      end
      k = $urandom_range(15);
      while (m_face[k]) k = (k + 1) % 16;
      do_flip(4'(k), $urandom_range(2) != 0, $urandom_range(7) == 0, $urandom_range(15) == 0);
    end

    repeat (R + 8) step();
    check("pending expectations", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
